cas_lock_seq: RTL and testbench
===============================

CAS_LOCK_SEQ -- requirements
Module: cas_lock_seq

Interface
REQ-001 SHALL have parameter W, default 32, meaning primary-input width; legal range 2..64.
REQ-002 SHALL have parameter CHAIN_PATTERN, width W-1, default all-zero, meaning the gate type per chain stage: bit j-1 = 1 selects OR at stage j, 0 selects AND.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the flip-counter width.
REQ-004 clk  input  1  rising-edge clock; the block has one clock only.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 key_load  input  1  single-cycle pulse that starts a (re)load of the key.
REQ-007 key_valid  input  1  key_bit is valid this cycle.
REQ-008 key_bit  input  1  serial key bit, key index 0 first.
REQ-009 key_ready  output  1  block accepts key bits (state LOAD).
REQ-010 armed  output  1  full 2W-bit key is loaded (state ARMED).
REQ-011 in_valid  input  1  in_data and orig_bit are valid.
REQ-012 in_ready  output  1  block accepts data (state ARMED).
REQ-013 in_data  input  W  primary inputs feeding the CAS chains.
REQ-014 orig_bit  input  1  unlocked output of the protected circuit for this vector.
REQ-015 out_valid  output  1  out_bit is valid; single-cycle pulse, no backpressure.
REQ-016 out_bit  output  1  locked output, orig_bit XOR casop.
REQ-017 flip_cnt  output  CNT_W  saturating count of outputs with casop=1.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, ARMED; key_load in any state SHALL go to LOAD next cycle with the bit counter cleared.
REQ-019 In LOAD, each cycle with key_valid=1 SHALL write key_bit to key[cnt] and increment cnt; the accept that makes cnt reach 2W SHALL move the FSM to ARMED next cycle.
REQ-020 key_valid outside LOAD SHALL be ignored; key_load and key_valid in the same LOAD cycle SHALL restart at cnt=0 and discard that bit.
REQ-021 Key bits 0..W-1 SHALL form chain-A key KA; bits W..2W-1 SHALL form chain-B key KB.
REQ-022 An input handshake (in_valid && in_ready) SHALL register xa = in_data^KA, xb = in_data^KB and orig_bit in stage 1.
REQ-023 Chain evaluation per key: c0 = x[0]; c_j = x[j] OR c_{j-1} if CHAIN_PATTERN[j-1]=1, else x[j] AND c_{j-1}; chain result = c_{W-1}.
REQ-024 casop SHALL equal chainA AND NOT chainB; stage 2 SHALL register out_bit = orig_bit XOR casop and out_valid.
REQ-025 Latency SHALL be exactly 2 cycles from the handshake to out_valid; throughput one vector per cycle.
REQ-026 A key_load in ARMED SHALL NOT corrupt vectors already accepted, since stage 1 holds pre-XORed values; in-flight vectors SHALL complete.
REQ-027 key_load and an accepted in_valid in the same ARMED cycle SHALL accept the vector with the old key.
REQ-028 flip_cnt SHALL increment on each out_valid with casop=1 and SHALL saturate at 2^CNT_W-1.
REQ-029 in_ready SHALL be 0 and in_valid ignored in IDLE and LOAD.

Reset
REQ-030 With rst=1 at a clock edge, the next state SHALL be IDLE, with key=0, cnt=0, pipeline valids=0, out_bit=0, out_valid=0, flip_cnt=0, key_ready=0, armed=0, in_ready=0.
REQ-031 Reset SHALL take priority over key_load, key_valid and in_valid, including mid-LOAD and with vectors in flight; in-flight vectors SHALL be dropped with no out_valid.

Verification (W=4, CHAIN_PATTERN=3'b010, CNT_W=4)
REQ-032 Reset then key_load -> key_ready=1 next cycle; serial key 0,0,0,0,0,0,1,0 (KA=0000, KB=0100) -> armed=1 and in_ready=1 one cycle after the 8th bit.
REQ-033 Armed as in REQ-032, in_data=1100, orig_bit=0 -> two cycles later out_valid=1, out_bit=1, flip_cnt=1.
REQ-034 Same key, in_data=1000, orig_bit=1 -> out_bit=1 (casop=0), flip_cnt unchanged.
REQ-035 Back-to-back vectors 1100 then 1000 with key_load asserted on the second vector's cycle -> both outputs produced on consecutive cycles with old-key results, then key_ready=1.
REQ-036 16 consecutive casop=1 vectors -> flip_cnt=15 and held there.
REQ-037 rst asserted after 5 key bits, or with 2 vectors in flight -> IDLE, no out_valid, all outputs 0, armed=0.

Source files
------------

// File: rtl/cas_lock_seq.sv
// CAS-lock sequencer: serial key load, two CAS chains, locked output.
// Two-stage datapath with a saturating count of flipped outputs.
module cas_lock_seq #(
    parameter int unsigned           W             = 32,
    parameter logic [W-2:0]          CHAIN_PATTERN = '0,
    parameter int unsigned           CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic             key_valid,
    input  logic             key_bit,
    output logic             key_ready,
    output logic             armed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             orig_bit,
    output logic             out_valid,
    output logic             out_bit,
    output logic [CNT_W-1:0] flip_cnt
);

    localparam int unsigned KW = 2 * W;
    localparam int unsigned CW = $clog2(KW + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARMED
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   key_q, key_d;

    logic            s1_valid_q;
    logic [W-1:0]    xa_q;
    logic [W-1:0]    xb_q;
    logic            orig_q;
    logic            out_valid_q;
    logic            out_bit_q;
    logic [CNT_W-1:0] flip_q;

    logic            hs;
    logic            chain_a;
    logic            chain_b;
    logic            casop;

    // Gate chain: stage j combines x[j] with the previous stage result.
    function automatic logic chain_eval(input logic [W-1:0] x);
        logic c;
        c = x[0];
        for (int j = 1; j < W; j++) begin
            if (CHAIN_PATTERN[j-1]) c = x[j] | c;
            else                    c = x[j] & c;
        end
        return c;
    endfunction

    // FSM state, key bit counter and key register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
        end
    end

    // Next state: key_load restarts loading from any state and wins over key_valid.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        if (key_load) begin
            state_d = LOAD;
            cnt_d   = '0;
        end else if (state_q == LOAD && key_valid) begin
            for (int i = 0; i < KW; i++) begin
                if (cnt_q == CW'(i)) key_d[i] = key_bit;
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(KW - 1)) state_d = ARMED;
        end
    end

    // Handshake status decoded from the current state.
    always_comb begin
        key_ready = 1'b0;
        armed     = 1'b0;
        case (state_q)
            LOAD:    key_ready = 1'b1;
            ARMED:   armed     = 1'b1;
            default: ;
        endcase
    end

    assign in_ready = armed;
    assign hs       = in_valid && in_ready;

    assign chain_a = chain_eval(xa_q);
    assign chain_b = chain_eval(xb_q);
    assign casop   = chain_a & ~chain_b;

    // Stage 1 keeps pre-keyed operands so a reload cannot disturb them.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            xa_q       <= '0;
            xb_q       <= '0;
            orig_q     <= 1'b0;
        end else begin
            s1_valid_q <= hs;
            if (hs) begin
                xa_q   <= in_data ^ key_q[W-1:0];
                xb_q   <= in_data ^ key_q[KW-1:W];
                orig_q <= orig_bit;
            end
        end
    end

    // Stage 2 produces the locked bit and counts flipped outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            flip_q      <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_bit_q <= orig_q ^ casop;
                if (casop && flip_q != '1) flip_q <= flip_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign flip_cnt  = flip_q;

endmodule

// File: tb/tb_cas_lock_seq.sv
// Directed bench for cas_lock_seq with W=4, CHAIN_PATTERN=3'b010, CNT_W=4.
// Expected values are hand-computed from the chain equations.
module tb_cas_lock_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_load = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_bit = 1'b0;
    logic       key_ready;
    logic       armed;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       orig_bit = 1'b0;
    logic       out_valid;
    logic       out_bit;
    logic [3:0] flip_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // KA = 0000, KB = 0100 -> only key index 6 is set
    logic [7:0] key_vec = 8'b0100_0000;

    cas_lock_seq #(
        .W(4),
        .CHAIN_PATTERN(3'b010),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_load(key_load),
        .key_valid(key_valid),
        .key_bit(key_bit),
        .key_ready(key_ready),
        .armed(armed),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .orig_bit(orig_bit),
        .out_valid(out_valid),
        .out_bit(out_bit),
        .flip_cnt(flip_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_key_ready"}, 32'(key_ready), 32'd0);
        chk({tag, "_armed"},     32'(armed),     32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_bit"},   32'(out_bit),   32'd0);
        chk({tag, "_flip_cnt"},  32'(flip_cnt),  32'd0);
    endtask

    // Shift in key bits 0..n-1 of key_vec, one per cycle.
    task automatic send_key(input int n);
        for (int i = 0; i < n; i++) begin
            key_valid = 1'b1;
            key_bit   = key_vec[i];
            tick();
        end
        key_valid = 1'b0;
        key_bit   = 1'b0;
    endtask

    task automatic pulse_load();
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    // One vector, then check out_valid timing and result.
    task automatic one_vec(input string tag, input logic [3:0] d,
                           input logic o, input logic exp_bit,
                           input logic [3:0] exp_cnt);
        in_valid = 1'b1;
        in_data  = d;
        orig_bit = o;
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_bit"},   32'(out_bit),   32'(exp_bit));
        chk({tag, "_cnt"},   32'(flip_cnt),  32'(exp_cnt));
        tick();
        chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        // Reset, with key_load also asserted: reset wins
        rst      = 1'b1;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        tick();
        rst = 1'b0;
        chk_idle("reset");

        // key_valid in IDLE is ignored, nothing arms
        send_key(8);
        chk("idle_keyvalid_armed", 32'(armed), 32'd0);

        // Load key
        pulse_load();
        chk("load_key_ready", 32'(key_ready), 32'd1);
        chk("load_in_ready",  32'(in_ready),  32'd0);
        send_key(7);
        chk("bit7_armed", 32'(armed), 32'd0);
        key_vec = 8'b0100_0000;
        key_valid = 1'b1;
        key_bit   = key_vec[7];
        tick();
        key_valid = 1'b0;
        chk("bit8_armed",     32'(armed),     32'd1);
        chk("bit8_in_ready",  32'(in_ready),  32'd1);
        chk("bit8_key_ready", 32'(key_ready), 32'd0);

        // 1100 orig 0 -> casop 1 -> out 1, cnt 1
        one_vec("v1100", 4'b1100, 1'b0, 1'b1, 4'd1);
        // 1000 orig 1 -> casop 0 -> out 1, cnt 1
        one_vec("v1000", 4'b1000, 1'b1, 1'b1, 4'd1);
        // 0000 orig 0 -> casop 0 -> out 0
        one_vec("v0000", 4'b0000, 1'b0, 1'b0, 4'd1);
        // 0111 orig 1: xa=0111 chainA=0 -> out 1
        one_vec("v0111", 4'b0111, 1'b1, 1'b1, 4'd1);

        // Back-to-back, key_load on second vector's cycle
        in_valid = 1'b1;
        in_data  = 4'b1100;
        orig_bit = 1'b0;
        tick();
        in_data  = 4'b1000;
        orig_bit = 1'b1;
        key_load = 1'b1;
        tick();
        in_valid = 1'b0;
        key_load = 1'b0;
        chk("b2b_key_ready", 32'(key_ready), 32'd1);
        chk("b2b_in_ready",  32'(in_ready),  32'd0);
        chk("b2b_v1_valid",  32'(out_valid), 32'd1);
        chk("b2b_v1_bit",    32'(out_bit),   32'd1);
        chk("b2b_v1_cnt",    32'(flip_cnt),  32'd2);
        tick();
        chk("b2b_v2_valid", 32'(out_valid), 32'd1);
        chk("b2b_v2_bit",   32'(out_bit),   32'd1);
        chk("b2b_v2_cnt",   32'(flip_cnt),  32'd2);
        tick();
        chk("b2b_end_valid", 32'(out_valid), 32'd0);

        // in_valid in LOAD is ignored
        in_valid = 1'b1;
        in_data  = 4'b1100;
        tick();
        tick();
        in_valid = 1'b0;
        chk("load_ignore_valid", 32'(out_valid), 32'd0);
        tick();
        chk("load_ignore_cnt", 32'(flip_cnt), 32'd2);

        // key_load with key_valid: bit discarded, count restarts
        key_load  = 1'b1;
        key_valid = 1'b1;
        key_bit   = 1'b1;
        tick();
        key_load = 1'b0;
        send_key(7);
        chk("restart_bit7_armed", 32'(armed), 32'd0);
        key_valid = 1'b1;
        key_bit   = key_vec[7];
        tick();
        key_valid = 1'b0;
        chk("restart_bit8_armed", 32'(armed), 32'd1);
        one_vec("reload_v1100", 4'b1100, 1'b0, 1'b1, 4'd3);

        // Reset with vectors in flight
        in_valid = 1'b1;
        in_data  = 4'b1100;
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk_idle("rst_flight");
        tick();
        chk("rst_flight_after_valid", 32'(out_valid), 32'd0);
        tick();
        chk("rst_flight_after2_valid", 32'(out_valid), 32'd0);

        // Reset mid-LOAD after 5 bits
        pulse_load();
        send_key(5);
        chk("midload_key_ready", 32'(key_ready), 32'd1);
        rst       = 1'b1;
        key_valid = 1'b1;
        tick();
        rst       = 1'b0;
        key_valid = 1'b0;
        chk_idle("rst_midload");
        tick();
        chk("rst_midload_stay", 32'(key_ready), 32'd0);

        // Saturation: 16 consecutive casop=1 vectors
        pulse_load();
        send_key(8);
        chk("sat_armed", 32'(armed), 32'd1);
        in_valid = 1'b1;
        in_data  = 4'b1100;
        orig_bit = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        chk("sat_cnt14", 32'(flip_cnt), 32'd14);
        tick();
        in_valid = 1'b0;
        chk("sat_cnt15a", 32'(flip_cnt), 32'd15);
        tick();
        chk("sat_last_valid", 32'(out_valid), 32'd1);
        chk("sat_cnt15b",     32'(flip_cnt),  32'd15);
        one_vec("sat_hold", 4'b1100, 1'b0, 1'b1, 4'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
